// File: rtl/dm_pkg.sv
// ============================================================================
// Module      : dm_pkg
// Description : Shared encodings, FSM state type and alignment check for the
//               pipelined data memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dm_pkg;

  localparam logic [1:0] SZ_W = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_B = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } dm_state_t;

  // Reserved size never aligns, so it doubles as the error condition.
  function automatic logic dm_aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_W:    return (lo == 2'b00);
      SZ_H:    return !lo[0];
      SZ_B:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_lane.sv
// ============================================================================
// Module      : dm_lane
// Description : One byte-wide memory bank with synchronous write and
//               combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_lane
  import dm_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/dm_pipelined.sv
// ============================================================================
// Module      : dm_pipelined
// Description : Byte-addressed data memory with valid/ready requests, fixed
//               LATENCY responses and a post-reset clear sequencer.
//               Define DM_TRACE_EN to print a line for every committed store.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_pipelined
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int            WI     = ADDR_W - 2;
  localparam int            WORDS  = 2 ** WI;
  localparam logic [WI-1:0] C_LAST = WI'(WORDS - 1);

  dm_state_t     r_state, w_state_next;
  logic [WI-1:0] r_clr_cnt, w_clr_next;
  logic          w_clearing;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clr_next   = r_clr_cnt;
    w_clearing   = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clearing = !Reset;
        w_clr_next = r_clr_cnt + 1'b1;
        if (r_clr_cnt == C_LAST) w_state_next = READY;
      end
      READY:   ;
      default: w_state_next = CLEAR;
    endcase
  end

  logic          w_accept, w_ok, w_store;
  logic [WI-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_lane_wdata, w_rd_word;

  assign req_ready = (r_state == READY) && !Reset;
  assign w_accept  = req_valid && req_ready;
  assign w_ok      = dm_aligned(req_size, req_addr[1:0]);
  assign w_store   = w_accept && req_we && w_ok;
  assign w_idx     = req_addr[ADDR_W-1:2];

  // Store data is replicated across lanes so each lane just takes its own byte.
  always_comb begin
    w_be         = 4'b0000;
    w_lane_wdata = req_wdata;
    case (req_size)
      SZ_W: w_be = 4'b1111;
      SZ_H: begin
        w_be         = req_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_wdata = {2{req_wdata[15:0]}};
      end
      SZ_B: begin
        w_be         = 4'b0001 << req_addr[1:0];
        w_lane_wdata = {4{req_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  generate
    for (genvar g = 0; g < 4; g++) begin : g_lane
      dm_lane #(
        .DEPTH (WORDS),
        .AW    (WI)
      ) u_lane (
        .Clk   (Clk),
        .we    (w_clearing || (w_store && w_be[g])),
        .waddr (w_clearing ? r_clr_cnt : w_idx),
        .wdata (w_clearing ? 8'h00 : w_lane_wdata[8*g +: 8]),
        .raddr (w_idx),
        .rdata (w_rd_word[8*g +: 8])
      );
    end
  endgenerate

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load, w_rsp_data;

  always_comb begin
    w_byte = w_rd_word[{req_addr[1:0], 3'b000} +: 8];
    w_half = req_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    w_load = '0;
    case (req_size)
      SZ_W: w_load = w_rd_word;
      SZ_H: w_load = req_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      SZ_B: w_load = req_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      default: ;
    endcase
    w_rsp_data = (!req_we && w_ok) ? w_load : 32'h0;
  end

  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_err;
  logic [31:0]        r_data [LATENCY];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < LATENCY; i++) r_data[i] <= '0;
    end else begin
      r_vld[0]  <= w_accept;
      r_err[0]  <= w_accept && !w_ok;
      r_data[0] <= w_accept ? w_rsp_data : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_err[i]  <= r_err[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign rsp_valid = r_vld[LATENCY-1];
  assign rsp_err   = r_err[LATENCY-1];
  assign rsp_rdata = r_data[LATENCY-1];

`ifdef DM_TRACE_EN
  logic [31:0] w_new_word;

  always_comb begin
    w_new_word = w_rd_word;
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) w_new_word[8*i +: 8] = w_lane_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge Clk) begin
    if (w_store) $display("@%h: *%h <= %h", req_pc, 32'(req_addr), w_new_word);
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^req_pc;
`endif

endmodule

`default_nettype wire

// File: doc/dm_pipelined.md
# dm_pipelined

Parametrised byte-addressed data memory for the MIPS CPU's MEM stage, successor to the single-cycle DM. Adds configurable depth and read latency, a valid/ready request port, unsigned loads, misalignment detection, and a hardware clear sequencer that zeroes the array word-by-word after reset. Stores and loads are fully pipelined: one request per cycle, every accepted request gets exactly one response.

## Interface
- ADDR_W, 12: byte-address width; array holds 2**ADDR_W bytes as 2**(ADDR_W-2) words (ADDR_W ≥ 3)
- LATENCY, 1: accept-to-response latency in cycles, legal 1..4
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept (high only in READY state)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 word, 01 half, 10 byte, 11 reserved
- req_unsigned  in  1  zero-extend load data (lbu/lhu); ignored for word/store
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, low bytes used for half/byte
- req_pc  in  32  PC of issuing instruction (trace only)
- rsp_valid  out  1  response present, one cycle
- rsp_rdata  out  32  load data (extended); 0 for stores and errors
- rsp_err  out  1  misaligned or reserved-size request

## Operation
- FSM states: CLEAR, READY. Reset → CLEAR, clr_cnt = 0.
- CLEAR: each edge with Reset low writes 0 to word clr_cnt, increments; on clr_cnt == WORDS-1 writes last word and goes READY. req_ready = 0 throughout.
- READY: accept when req_valid && req_ready.
- Alignment: word needs addr[1:0]==0, half needs addr[0]==0; size 11 always errors. Errored request: no write, rsp_err=1, rsp_rdata=0.
- Store: byte lanes written at accept edge — word all four, half lanes {addr[1],0} and +1, byte lane addr[1:0]. Little-endian: byte A in bits 7:0.
- Load: word read combinationally at accept, byte/half selected, sign- or zero-extended, then delayed LATENCY-1 further stages.
- Read-after-write: load accepted the cycle after a store to same word sees new data. Same-cycle conflict impossible (one request/cycle).
- No response backpressure; consumer must take rsp every cycle it is valid.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, state CLEAR, all pipeline valids 0.
- req_ready rises after WORDS edges following Reset deassertion.
- Accept at edge N → rsp_valid high in the cycle after edge N+LATENCY-1, for exactly one cycle; back-to-back accepts give back-to-back responses in order.
- Reset mid-operation: in-flight responses dropped (valids cleared), clear restarts from word 0; memory contents during an interrupted clear are undefined until clear completes.
- req_valid without req_ready: ignored, no response, no write.

## Configuration
- DM_TRACE_EN defined: on every successful store edge, $display("@%h: *%h <= %h", req_pc, zero-extended req_addr, full 32-bit word after write). No print for errored stores or clear writes.
- Undefined: no $display; req_pc unused; RTL otherwise identical.

## Structure
- Package dm_pkg: size encodings (SZ_W, SZ_H, SZ_B), state enum (CLEAR, READY), alignment-check function.
- Sub-module dm_lane: one 8-bit-wide, WORDS-deep bank with write enable and combinational read; four instances, one per byte lane. Clear writes drive all four lanes.

## Test plan
- ADDR_W=6, LATENCY=2: release Reset → req_ready low for exactly 16 cycles, then high; load every word → all 0.
- sw 0x8765_4321 @0x08; lb @0x0B → 0xFFFF_FF87; lbu @0x0B → 0x0000_0087; lh @0x0A → 0xFFFF_8765; lhu @0x08 → 0x0000_4321; each rsp 2 cycles after accept.
- sh 0xBEEF @0x0C then sb 0x5A @0x0F back-to-back, lw @0x0C next cycle → 0x5A00_BEEF.
- lw @0x02, sh @0x05, size=11 @0x00 → rsp_err=1, rdata 0; following lw @0x04 shows memory unchanged.
- Issue 4 loads back-to-back, assert Reset on cycle of 2nd response → no further rsp_valid; clear re-runs 16 cycles; prior data reads 0.
- With DM_TRACE_EN, sw 0x1234_5678 @0x10, pc 0x3000 → log "@00003000: *00000010 <= 12345678".
